// File: rtl/booth_mul_arbiter_if.sv
// Request/response bundle between the requesters and booth_mul_arbiter.
//   master : requester side (drives operands and req_valid, consumes products)
//   slave  : arbiter side (grants with req_ready, returns tagged products)
// Signals:
//   req_valid[NREQ]  per-requester request valid
//   req_m/req_q      4-bit multiplicand/multiplier, slice i belongs to requester i
//   req_ready[NREQ]  one-hot accept
//   rsp_valid/ready  product handshake
//   rsp_id           requester that owns rsp_p
//   rsp_p            8-bit two's-complement product
interface booth_mul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_m;
    logic [4*NREQ-1:0] req_q;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [7:0]        rsp_p;

    modport master (
        output req_valid,
        output req_m,
        output req_q,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_p
    );

    modport slave (
        input  req_valid,
        input  req_m,
        input  req_q,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_p
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one 4-bit radix-2 Booth multiplier
// between NREQ requesters.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        booth_mul_arbiter_if.slave (request/response handshakes)
//   mul_reset  multiplier reset (active-high, synchronous inside the multiplier)
//   mul_load   multiplier load strobe
//   mul_m      multiplier M operand
//   mul_q      multiplier Q operand
//   mul_p      multiplier product
//   busy       high whenever the sequencer is not idle
module booth_mul_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned RUN_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    booth_mul_arbiter_if.slave        bus,
    output logic                      mul_reset,
    output logic                      mul_load,
    output logic [3:0]                mul_m,
    output logic [3:0]                mul_q,
    input  logic [7:0]                mul_p,
    output logic                      busy
);
    localparam int unsigned CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StCap,
        StResp
    } state_e;

    state_e          r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]      r_mul_m;
    logic [3:0]      r_mul_q;
    logic            r_mul_load;
    logic [7:0]      r_rsp_p;
    logic [ID_W-1:0] r_rsp_id;
    logic            r_rsp_valid;

    logic            w_grant_any;
    logic [ID_W-1:0] w_grant_idx;
    logic [NREQ-1:0] w_grant;
    logic [3:0]      w_sel_m;
    logic [3:0]      w_sel_q;

    // (base + off) mod NREQ
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return ID_W'(sum % NREQ);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_grant_any && bus.req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_m = '0;
        w_sel_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_m = bus.req_m[4*i +: 4];
                w_sel_q = bus.req_q[4*i +: 4];
            end
        end
    end

    // Grants only leave the block in IDLE and never while reset is held.
    assign bus.req_ready = (reset_n && (r_state == StIdle)) ? w_grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_mul_m     <= '0;
            r_mul_q     <= '0;
            r_mul_load  <= 1'b0;
            r_rsp_p     <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_any) begin
                        r_mul_m    <= w_sel_m;
                        r_mul_q    <= w_sel_q;
                        r_rsp_id   <= w_grant_idx;
                        r_rr_ptr   <= wrap_idx(w_grant_idx, 1);
                        r_mul_load <= 1'b1;
                        r_state    <= StLoad;
                    end
                end
                StLoad: begin
                    r_mul_load <= 1'b0;
                    r_cnt      <= CNT_W'(RUN_CYCLES - 1);
                    r_state    <= StRun;
                end
                StRun: begin
                    if (r_cnt == '0) begin
                        r_state <= StCap;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StCap: begin
                    r_rsp_p     <= mul_p;
                    r_rsp_valid <= 1'b1;
                    r_state     <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Multiplier is held cleared whenever it is not computing or feeding CAP.
    assign mul_reset     = (r_state == StIdle) || (r_state == StResp);
    assign mul_load      = r_mul_load;
    assign mul_m         = r_mul_m;
    assign mul_q         = r_mul_q;
    assign busy          = (r_state != StIdle);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_p     = r_rsp_p;
endmodule
